logic_unit_pipe: RTL and testbench
==================================

// Module: logic_unit_pipe
// PURPOSE
//  Parametrised, pipelined bitwise logic unit; successor to the fixed 32-bit AND gate.
//  Selects one of eight bitwise ops per transaction and registers the result through a
//  valid/ready pipeline of STAGES slices, with zero/parity flags for the ALU/branch path.
//  Sits in the execute stage beside the adder and accepts one operation per cycle.
// PARAMETERS
//  WIDTH   32  operand/result width in bits (>=1)
//  STAGES  2   pipeline register slices, legal range 1..4; latency in cycles
// PORTS
//  clk        in   1      rising-edge clock, sole clock domain
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      operands/op presented
//  in_ready   out  1      unit accepts the presented transaction this cycle
//  op         in   3      operation select, see BEHAVIOUR
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  out_valid  out  1      y/zero/parity hold a valid result
//  out_ready  in   1      consumer takes the result this cycle
//  y          out  WIDTH  result
//  zero       out  1      y == 0
//  parity     out  1      XOR-reduction of y (1 = odd number of ones)
// BEHAVIOUR
//  - Ops: 000 AND, 001 OR, 010 XOR, 011 NOR, 100 ANDN (a & ~b), 101 PASSA, 110 PASSB,
//    111 reserved -> y = 0. Compute combinationally; capture in slice 0 with the flags.
//  - Transfer occurs on any cycle with valid && ready at that interface.
//  - Slice k holds v[k] and data. rdy[STAGES] = out_ready; rdy[k] = !v[k] || rdy[k+1].
//    in_ready = rdy[0] (combinational chain; no combinational path from in_valid to in_ready).
//  - Slice k loads when rdy[k] is 1: v[k] <= upstream valid; data loads only when upstream
//    valid is 1, otherwise data holds. Bubbles collapse; a stalled head does not block
//    empty slices behind it.
//  - out_valid = v[STAGES-1]; y/zero/parity come from the last slice.
//  - Latency: with out_ready held 1, a result accepted at edge N is valid after edge
//    N+STAGES-1. Throughput is 1 per cycle.
//  - Backpressure: while out_valid && !out_ready, y/zero/parity/out_valid are stable.
//    Each full slice holds its data; no transaction is dropped or duplicated.
//  - Simultaneous: a full pipeline with out_ready=1 accepts a new input on the same edge
//    the head retires.
//  - Reset: all v[k] <= 0; y, zero, parity <= 0. out_valid = 0 and in_ready = 1 in the
//    cycle after rst. Reset mid-operation flushes in-flight results, which are lost.
//  - Width: all ops are bit-parallel over WIDTH; no carries. zero and parity are computed
//    from the WIDTH-bit result.
// STRUCTURE
//  - Package logic_unit_pkg: localparams OP_AND..OP_PASSB and OP_RSVD (3-bit codes),
//    plus the function logic_op(op, a, b) shared with the ALU.
//  - Sub-module logic_pipe_slice #(W): one valid/ready register slice with ports
//    v_in, rdy_out, d_in, v_out, rdy_in, d_out. Top = op decode + generate loop of
//    STAGES slices over {y, zero, parity}.
// TESTING (WIDTH=32, STAGES=2 unless noted)
//  1. AND a=0x17F13EE8 b=0xB0997F07, out_ready=1 -> 2 cycles later y=0x10913E00, zero=0.
//  2. Back-to-back OR then XOR on the same operands -> consecutive cycles give
//     y=0xB7F97FEF then y=0xA76841EF.
//  3. NOR a=0 b=0 -> y=0xFFFFFFFF, parity=0. AND a=0 b=0xB0997F07 -> y=0, zero=1.
//  4. out_ready=0 for 5 cycles with 3 inputs offered -> exactly 2 accepted, then in_ready=0.
//     y stays stable. Release -> results emerge in order, none lost.
//  5. rst asserted with 2 results in flight -> next cycle out_valid=0, y=0, in_ready=1.
//     Nothing emerges afterwards.
//  6. STAGES=1 and STAGES=4 with random ops and stalls vs. scoreboard model -> latency
//     equals STAGES, all op codes match, reserved op 111 gives y=0.

Source files
------------

// File: rtl/logic_unit_pkg.sv
// Op encodings and the per-bit logic function shared by the logic unit and the ALU.
package logic_unit_pkg;

  localparam logic [2:0] OP_AND   = 3'b000;
  localparam logic [2:0] OP_OR    = 3'b001;
  localparam logic [2:0] OP_XOR   = 3'b010;
  localparam logic [2:0] OP_NOR   = 3'b011;
  localparam logic [2:0] OP_ANDN  = 3'b100;
  localparam logic [2:0] OP_PASSA = 3'b101;
  localparam logic [2:0] OP_PASSB = 3'b110;
  localparam logic [2:0] OP_RSVD  = 3'b111;

  // Single-bit form so any caller can apply it bit-parallel at its own width.
  function automatic logic logic_op(input logic [2:0] op, input logic a, input logic b);
    logic r;
    case (op)
      OP_AND:   r = a & b;
      OP_OR:    r = a | b;
      OP_XOR:   r = a ^ b;
      OP_NOR:   r = ~(a | b);
      OP_ANDN:  r = a & ~b;
      OP_PASSA: r = a;
      OP_PASSB: r = b;
      default:  r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/logic_pipe_slice.sv
// One valid/ready register slice: latency 1 cycle; ready to upstream whenever the slice
// is empty or downstream is ready, so bubbles collapse and a full slice holds under stall.
module logic_pipe_slice
  import logic_unit_pkg::*;
#(
  parameter int W = 34
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         v_in,
  output logic         rdy_out,
  input  logic [W-1:0] d_in,
  output logic         v_out,
  input  logic         rdy_in,
  output logic [W-1:0] d_out
);

  assign rdy_out = !v_out || rdy_in;

  always_ff @(posedge clk) begin
    if (rst) begin
      v_out <= 1'b0;
      d_out <= '0;
    end else if (rdy_out) begin
      v_out <= v_in;
      // Data only moves with a real transaction; a bubble leaves the old value in place.
      if (v_in) d_out <= d_in;
    end
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// Pipelined bitwise logic unit with zero/parity flags: latency STAGES cycles, 1 op/cycle;
// in_ready falls only when every slice is full and out_ready is low, outputs hold while stalled.
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             parity
);

  localparam int DW = WIDTH + 2;

  logic [WIDTH-1:0] res;
  logic [DW-1:0]    head_d;

  if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
    $error("logic_unit_pipe: STAGES must be in 1..4");
  end

  always_comb begin
    res = '0;
    for (int i = 0; i < WIDTH; i++) begin
      res[i] = logic_op(op, a[i], b[i]);
    end
  end

  assign head_d = {res, ~|res, ^res};

  // Per-stage locals keep the backward ready chain free of self-referencing vectors.
  for (genvar k = 0; k < STAGES; k++) begin : g_slice
    logic          v_up;
    logic          rdy_up;
    logic          v_q;
    logic          rdy_dn;
    logic [DW-1:0] d_up;
    logic [DW-1:0] d_q;

    if (k == 0) begin : g_head
      assign v_up = in_valid;
      assign d_up = head_d;
    end else begin : g_mid
      assign v_up = g_slice[k-1].v_q;
      assign d_up = g_slice[k-1].d_q;
    end

    if (k == STAGES - 1) begin : g_tail
      assign rdy_dn = out_ready;
    end else begin : g_next
      assign rdy_dn = g_slice[k+1].rdy_up;
    end

    logic_pipe_slice #(.W(DW)) u_slice (
      .clk     (clk),
      .rst     (rst),
      .v_in    (v_up),
      .rdy_out (rdy_up),
      .d_in    (d_up),
      .v_out   (v_q),
      .rdy_in  (rdy_dn),
      .d_out   (d_q)
    );
  end

  assign in_ready           = g_slice[0].rdy_up;
  assign out_valid          = g_slice[STAGES-1].v_q;
  assign {y, zero, parity}  = g_slice[STAGES-1].d_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Scoreboard bench for logic_unit_pipe at STAGES = 2, 1 and 4 with directed vectors.
module tb_logic_unit_pipe;

  localparam int W = 32;
  localparam int N = 3;
  localparam logic [W-1:0] VA = 32'h17F13EE8;
  localparam logic [W-1:0] VB = 32'hB0997F07;

  typedef struct {
    logic [W+1:0] want;
    int           edge_n;
    bit           ff;
  } item_t;

  typedef struct {
    string       nm;
    logic [63:0] act;
    logic [63:0] want;
  } req_t;

  logic clk = 1'b0;
  logic rst;
  logic [N-1:0] in_valid, in_ready, out_valid, out_ready, zero, parity, free_flow;
  logic [N-1:0][2:0]   op;
  logic [N-1:0][W-1:0] a, b, y;
  logic [N-1:0][W+1:0] cur_exp;

  item_t sbq[N][$];
  req_t  dq[$];
  int    n_in[N];
  int    n_out[N];
  int    checks = 0;
  int    failures = 0;
  int    cyc = 0;
  bit    stall_mode = 1'b0;

  logic [2:0]   t_op[12];
  logic [W-1:0] t_a[12];
  logic [W-1:0] t_b[12];
  logic [W-1:0] t_y[12];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < N; g++) begin : g_dut
    logic_unit_pipe #(.WIDTH(W), .STAGES(g == 0 ? 2 : (g == 1 ? 1 : 4))) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .op        (op[g]),
      .a         (a[g]),
      .b         (b[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .y         (y[g]),
      .zero      (zero[g]),
      .parity    (parity[g])
    );
  end

  function automatic int stg(int g);
    return (g == 0) ? 2 : ((g == 1) ? 1 : 4);
  endfunction

  task automatic cmp(string nm, logic [63:0] act, logic [63:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, want);
    end
  endtask

  task automatic post(string nm, logic [63:0] act, logic [63:0] want);
    req_t r;
    r.nm = nm;
    r.act = act;
    r.want = want;
    dq.push_back(r);
  endtask

  // Monitor: sole owner of the counters and scoreboards.
  initial begin
    item_t it;
    req_t  r;
    forever begin
      @(negedge clk);
      while (dq.size() > 0) begin
        r = dq.pop_front();
        cmp(r.nm, r.act, r.want);
      end
      for (int g = 0; g < N; g++) begin
        if (rst) begin
          sbq[g].delete();
          n_in[g] = n_out[g];
        end else begin
          if (out_valid[g] && out_ready[g]) begin
            n_out[g]++;
            cmp($sformatf("sb_has_item_dut%0d", g), 64'(sbq[g].size() != 0), 64'd1);
            if (sbq[g].size() != 0) begin
              it = sbq[g].pop_front();
              cmp($sformatf("result_dut%0d", g), 64'({y[g], zero[g], parity[g]}), 64'(it.want));
              if (it.ff) cmp($sformatf("latency_dut%0d", g), 64'(cyc + 1 - it.edge_n), 64'(stg(g)));
            end
          end
          if (in_valid[g] && in_ready[g]) begin
            it.want = cur_exp[g];
            it.edge_n = cyc + 1;
            it.ff = free_flow[g];
            sbq[g].push_back(it);
            n_in[g]++;
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(int g, logic [2:0] o, logic [W-1:0] av, logic [W-1:0] bv, logic [W-1:0] ey);
    bit ok = 1'b0;
    int n = 0;
    op[g] = o;
    a[g] = av;
    b[g] = bv;
    cur_exp[g] = {ey, ~|ey, ^ey};
    in_valid[g] = 1'b1;
    while (!ok && n < 200) begin
      if (stall_mode) out_ready[g] = 1'($urandom_range(0, 1));
      @(negedge clk);
      ok = in_ready[g];
      n++;
      step();
    end
    post($sformatf("send_accepted_dut%0d", g), 64'(ok), 64'd1);
  endtask

  task automatic idle(int g);
    in_valid[g] = 1'b0;
    a[g] = $urandom;
    b[g] = $urandom;
    op[g] = 3'($urandom);
  endtask

  task automatic drain(int g);
    int n = 0;
    while (n_out[g] != n_in[g] && n < 200) begin
      if (stall_mode) out_ready[g] = 1'($urandom_range(0, 1));
      @(negedge clk);
      n++;
      step();
    end
    post($sformatf("drained_dut%0d", g), 64'(n_out[g] == n_in[g]), 64'd1);
    out_ready[g] = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cycle=%0d required=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int base;
    t_op = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110, 3'b111,
             3'b111, 3'b011, 3'b100, 3'b010};
    t_a  = '{VA, VA, VA, VA, VA, VA, VA, VA,
             32'hFFFFFFFF, 32'hFFFF0000, 32'hFFFFFFFF, 32'hFFFFFFFF};
    t_b  = '{VB, VB, VB, VB, VB, VB, VB, VB,
             32'hFFFFFFFF, 32'h00FF00FF, 32'h0F0F0F0F, 32'h0F0F0F0F};
    t_y  = '{32'h10913E00, 32'hB7F97FEF, 32'hA76841EF, 32'h48068010, 32'h076000E8, VA, VB,
             32'h00000000, 32'h00000000, 32'h0000FF00, 32'hF0F0F0F0, 32'hF0F0F0F0};

    rst = 1'b1;
    in_valid = '0;
    out_ready = '1;
    free_flow = '1;
    op = '0;
    a = '0;
    b = '0;
    cur_exp = '0;
    repeat (3) step();
    rst = 1'b0;
    for (int g = 0; g < N; g++) begin
      post($sformatf("rst_out_valid_dut%0d", g), 64'(out_valid[g]), 64'd0);
      post($sformatf("rst_in_ready_dut%0d", g), 64'(in_ready[g]), 64'd1);
      post($sformatf("rst_y_flags_dut%0d", g), 64'({y[g], zero[g], parity[g]}), 64'd0);
    end

    // Single AND, then back-to-back OR/XOR, then bubbles must not disturb the held result.
    send(0, 3'b000, VA, VB, 32'h10913E00);
    idle(0);
    drain(0);
    send(0, 3'b001, VA, VB, 32'hB7F97FEF);
    send(0, 3'b010, VA, VB, 32'hA76841EF);
    idle(0);
    drain(0);
    step();
    step();
    post("bubble_hold_y", 64'(y[0]), 64'(32'hA76841EF));
    send(0, 3'b011, 32'h0, 32'h0, 32'hFFFFFFFF);
    send(0, 3'b000, 32'h0, VB, 32'h0);
    idle(0);
    drain(0);

    // Stall: three offered over five cycles, two fit, head stays put.
    free_flow[0] = 1'b0;
    out_ready[0] = 1'b0;
    base = n_out[0];
    acc = 0;
    for (int c = 0; c < 5; c++) begin
      op[0] = t_op[5 + acc];
      a[0] = VA;
      b[0] = VB;
      cur_exp[0] = {t_y[5 + acc], ~|t_y[5 + acc], ^t_y[5 + acc]};
      if (acc == 2) begin
        op[0] = 3'b100;
        cur_exp[0] = {32'h076000E8, 1'b0, ^32'h076000E8};
      end
      in_valid[0] = 1'b1;
      @(negedge clk);
      if (in_ready[0]) acc++;
      if (c >= 2) begin
        post("stall_out_valid", 64'(out_valid[0]), 64'd1);
        post("stall_y_stable", 64'(y[0]), 64'(VA));
      end
      step();
    end
    post("stall_accepted", 64'(acc), 64'd2);
    post("stall_in_ready", 64'(in_ready[0]), 64'd0);
    out_ready[0] = 1'b1;
    send(0, 3'b100, VA, VB, 32'h076000E8);
    idle(0);
    drain(0);
    post("stall_none_lost", 64'(n_out[0] - base), 64'd3);

    // Reset with two results in flight flushes them.
    out_ready[0] = 1'b0;
    send(0, 3'b001, VA, VB, 32'hB7F97FEF);
    send(0, 3'b010, VA, VB, 32'hA76841EF);
    idle(0);
    base = n_out[0];
    rst = 1'b1;
    step();
    rst = 1'b0;
    post("flush_out_valid", 64'(out_valid[0]), 64'd0);
    post("flush_y", 64'(y[0]), 64'd0);
    post("flush_in_ready", 64'(in_ready[0]), 64'd1);
    out_ready[0] = 1'b1;
    repeat (10) step();
    post("flush_nothing_emerges", 64'(n_out[0] - base), 64'd0);

    // Full op table on every depth: free-flowing (latency checked), then with random stalls.
    for (int g = 0; g < N; g++) begin
      free_flow[g] = 1'b1;
      stall_mode = 1'b0;
      for (int i = 0; i < 12; i++) send(g, t_op[i], t_a[i], t_b[i], t_y[i]);
      idle(g);
      drain(g);
      free_flow[g] = 1'b0;
      stall_mode = 1'b1;
      for (int i = 0; i < 12; i++) send(g, t_op[i], t_a[i], t_b[i], t_y[i]);
      idle(g);
      drain(g);
      stall_mode = 1'b0;
      out_ready[g] = 1'b1;
    end

    repeat (3) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
